// File: rtl/vcfg_stripmine.sv
// Vector configuration unit with strip-mining sequencer: it accepts a SEW/LMUL/AVL
// configuration and then issues successive strips of at most VLMAX elements.
module vcfg_stripmine #(
    parameter int VLEN  = 128,
    parameter int ELEN  = 64,
    parameter int AVL_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [2:0]       cfg_sew,
    input  logic [2:0]       cfg_lmul,
    input  logic [AVL_W-1:0] cfg_avl,
    input  logic             strip_next,
    input  logic             abort,
    output logic [AVL_W-1:0] vl,
    output logic [6:0]       vtype,
    output logic             vill,
    output logic [AVL_W-1:0] avl_rem,
    output logic [AVL_W-1:0] strip_cnt,
    output logic             strip_last,
    output logic             done
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t           state_q, state_d;
    logic [AVL_W-1:0] vl_q, vl_d;
    logic [6:0]       vtype_q, vtype_d;
    logic             vill_q, vill_d;
    logic [AVL_W-1:0] avl_rem_q, avl_rem_d;
    logic [AVL_W-1:0] strip_cnt_q, strip_cnt_d;
    logic             done_q, done_d;
    logic [AVL_W-1:0] vlmax_q, vlmax_d;

    logic [31:0]      sew_bits;
    logic             cfg_legal;
    logic [AVL_W-1:0] cfg_vlmax;
    logic [AVL_W-1:0] cfg_first;
    logic [AVL_W-1:0] rem_step;

    // Decode of the incoming request; only meaningful while IDLE.
    always_comb begin
        sew_bits  = 32'd8 << cfg_sew[1:0];
        cfg_legal = !cfg_lmul[2] && !cfg_sew[2] && (sew_bits <= 32'(ELEN));
        cfg_vlmax = AVL_W'((32'(VLEN) >> (32'd3 + 32'(cfg_sew[1:0]))) << cfg_lmul[1:0]);
        cfg_first = (cfg_avl < cfg_vlmax) ? cfg_avl : cfg_vlmax;
        rem_step  = (avl_rem_q < vlmax_q) ? avl_rem_q : vlmax_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            vl_q        <= '0;
            vtype_q     <= '0;
            vill_q      <= 1'b0;
            avl_rem_q   <= '0;
            strip_cnt_q <= '0;
            done_q      <= 1'b0;
            vlmax_q     <= '0;
        end else begin
            state_q     <= state_d;
            vl_q        <= vl_d;
            vtype_q     <= vtype_d;
            vill_q      <= vill_d;
            avl_rem_q   <= avl_rem_d;
            strip_cnt_q <= strip_cnt_d;
            done_q      <= done_d;
            vlmax_q     <= vlmax_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cfg_valid && cfg_legal && (cfg_avl != '0)) state_d = ACTIVE;
            ACTIVE:  if (abort || (strip_next && (avl_rem_q == '0))) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        vl_d        = vl_q;
        vtype_d     = vtype_q;
        vill_d      = vill_q;
        avl_rem_d   = avl_rem_q;
        strip_cnt_d = strip_cnt_q;
        vlmax_d     = vlmax_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    if (!cfg_legal) begin
                        vill_d      = 1'b1;
                        vtype_d     = '0;
                        vl_d        = '0;
                        avl_rem_d   = '0;
                        strip_cnt_d = '0;
                        done_d      = 1'b1;
                    end else begin
                        vill_d  = 1'b0;
                        vtype_d = {1'b1, cfg_sew, cfg_lmul};
                        vlmax_d = cfg_vlmax;
                        if (cfg_avl == '0) begin
                            vl_d        = '0;
                            avl_rem_d   = '0;
                            strip_cnt_d = '0;
                            done_d      = 1'b1;
                        end else begin
                            vl_d        = cfg_first;
                            avl_rem_d   = cfg_avl - cfg_first;
                            strip_cnt_d = AVL_W'(1);
                        end
                    end
                end
            end
            ACTIVE: begin
                // Abort wins over a simultaneous strip_next and never pulses done.
                if (abort) begin
                    vl_d      = '0;
                    avl_rem_d = '0;
                end else if (strip_next) begin
                    if (avl_rem_q == '0) begin
                        done_d = 1'b1;
                    end else begin
                        vl_d        = rem_step;
                        avl_rem_d   = avl_rem_q - rem_step;
                        strip_cnt_d = strip_cnt_q + AVL_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        cfg_ready  = (state_q == IDLE);
        strip_last = (state_q == ACTIVE) && (avl_rem_q == '0);
        vl         = vl_q;
        vtype      = vtype_q;
        vill       = vill_q;
        avl_rem    = avl_rem_q;
        strip_cnt  = strip_cnt_q;
        done       = done_q;
    end

endmodule

// File: tb/tb_vcfg_stripmine.sv
// Self-checking bench: two instances (ELEN=64 and ELEN=32) driven in parallel and
// checked every cycle against a sequence-level reference model, plus directed cases.
module tb_vcfg_stripmine;
    localparam int AVL_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_valid;
    logic [2:0]       cfg_sew;
    logic [2:0]       cfg_lmul;
    logic [AVL_W-1:0] cfg_avl;
    logic             strip_next;
    logic             abort;

    logic [AVL_W-1:0] o_vl[2];
    logic [AVL_W-1:0] o_rem[2];
    logic [AVL_W-1:0] o_cnt[2];
    logic [6:0]       o_vtype[2];
    logic             o_vill[2];
    logic             o_ready[2];
    logic             o_last[2];
    logic             o_done[2];

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            vcfg_stripmine #(.VLEN(128), .ELEN((gi == 0) ? 64 : 32), .AVL_W(AVL_W)) u_dut (
                .clk        (clk),
                .rst        (rst),
                .cfg_valid  (cfg_valid),
                .cfg_ready  (o_ready[gi]),
                .cfg_sew    (cfg_sew),
                .cfg_lmul   (cfg_lmul),
                .cfg_avl    (cfg_avl),
                .strip_next (strip_next),
                .abort      (abort),
                .vl         (o_vl[gi]),
                .vtype      (o_vtype[gi]),
                .vill       (o_vill[gi]),
                .avl_rem    (o_rem[gi]),
                .strip_cnt  (o_cnt[gi]),
                .strip_last (o_last[gi]),
                .done       (o_done[gi])
            );
        end
    endgenerate

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model: tracks the sequence as "elements still to hand out".
    bit         m_act[2];
    int         m_vl[2], m_rem[2], m_cnt[2], m_vlmax[2];
    logic [6:0] m_vtype[2];
    bit         m_vill[2], m_done[2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_act[k] <= 0; m_vl[k] <= 0; m_rem[k] <= 0; m_cnt[k] <= 0;
                m_vlmax[k] <= 0; m_vtype[k] <= '0; m_vill[k] <= 0; m_done[k] <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                automatic int elen = (k == 0) ? 64 : 32;
                automatic int vl_n = m_vl[k], rem_n = m_rem[k], cnt_n = m_cnt[k];
                automatic int vlmax_n = m_vlmax[k];
                automatic bit act_n = m_act[k], vill_n = m_vill[k], done_n = 0;
                automatic logic [6:0] vt_n = m_vtype[k];
                automatic int sew = int'(cfg_sew), lmul = int'(cfg_lmul), avl = int'(cfg_avl);
                if (!m_act[k]) begin
                    if (cfg_valid) begin
                        if (lmul > 3 || sew > 3 || (8 << sew) > elen) begin
                            vill_n = 1; vt_n = '0; vl_n = 0; rem_n = 0; cnt_n = 0; done_n = 1;
                        end else begin
                            vill_n = 0;
                            vt_n = {1'b1, cfg_sew, cfg_lmul};
                            vlmax_n = (128 / (8 << sew)) * (1 << lmul);
                            if (avl == 0) begin
                                vl_n = 0; rem_n = 0; cnt_n = 0; done_n = 1;
                            end else begin
                                vl_n = (avl < vlmax_n) ? avl : vlmax_n;
                                rem_n = avl - vl_n; cnt_n = 1; act_n = 1;
                            end
                        end
                    end
                end else if (abort) begin
                    act_n = 0; vl_n = 0; rem_n = 0;
                end else if (strip_next) begin
                    if (m_rem[k] == 0) begin
                        act_n = 0; done_n = 1;
                    end else begin
                        vl_n = (m_rem[k] < vlmax_n) ? m_rem[k] : vlmax_n;
                        rem_n = m_rem[k] - vl_n; cnt_n = m_cnt[k] + 1;
                    end
                end
                m_act[k] <= act_n; m_vl[k] <= vl_n; m_rem[k] <= rem_n; m_cnt[k] <= cnt_n;
                m_vlmax[k] <= vlmax_n; m_vtype[k] <= vt_n; m_vill[k] <= vill_n; m_done[k] <= done_n;
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("ready[%0d]", k), o_ready[k], !m_act[k]);
                chk($sformatf("vl[%0d]", k), o_vl[k], m_vl[k]);
                chk($sformatf("rem[%0d]", k), o_rem[k], m_rem[k]);
                chk($sformatf("cnt[%0d]", k), o_cnt[k], m_cnt[k] & 32'hFF);
                chk($sformatf("vtype[%0d]", k), o_vtype[k], m_vtype[k]);
                chk($sformatf("vill[%0d]", k), o_vill[k], m_vill[k]);
                chk($sformatf("last[%0d]", k), o_last[k], m_act[k] && m_rem[k] == 0);
                chk($sformatf("done[%0d]", k), o_done[k], m_done[k]);
            end
        end
    end

    task automatic cfg(input int sew, input int lmul, input int avl);
        cfg_valid = 1'b1;
        cfg_sew   = 3'(sew);
        cfg_lmul  = 3'(lmul);
        cfg_avl   = AVL_W'(avl);
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 0; cfg_sew = 0; cfg_lmul = 0; cfg_avl = 0;
        strip_next = 0; abort = 0;
        #1;
        chk("rst_vl", o_vl[0], 0);
        chk("rst_vtype", o_vtype[0], 0);
        chk("rst_ready", o_ready[0], 1);
        chk("rst_last", o_last[0], 0);
        chk("rst_done", o_done[0], 0);
        @(negedge clk); rst = 1'b0;

        // Three strips of 16/16/8 elements
        cfg(0, 0, 40); @(negedge clk); cfg_valid = 0;
        chk("s1_vl", o_vl[0], 16); chk("s1_rem", o_rem[0], 24);
        chk("s1_cnt", o_cnt[0], 1); chk("s1_ready", o_ready[0], 0);
        strip_next = 1; @(negedge clk); strip_next = 0;
        chk("s2_vl", o_vl[0], 16); chk("s2_rem", o_rem[0], 8); chk("s2_cnt", o_cnt[0], 2);
        strip_next = 1; @(negedge clk); strip_next = 0;
        chk("s3_vl", o_vl[0], 8); chk("s3_rem", o_rem[0], 0);
        chk("s3_last", o_last[0], 1); chk("s3_cnt", o_cnt[0], 3);
        strip_next = 1; @(negedge clk); strip_next = 0;
        chk("s4_done", o_done[0], 1); chk("s4_ready", o_ready[0], 1);
        chk("s4_cnt", o_cnt[0], 3); chk("s4_vl", o_vl[0], 8); chk("s4_last", o_last[0], 0);
        @(negedge clk);
        chk("s5_done", o_done[0], 0);

        // Single strip, last on the first cycle
        cfg(2, 2, 10); @(negedge clk); cfg_valid = 0;
        chk("one_vl", o_vl[0], 10); chk("one_rem", o_rem[0], 0);
        chk("one_last", o_last[0], 1); chk("one_vtype", o_vtype[0], 7'b1010010);
        strip_next = 1; @(negedge clk); strip_next = 0;
        chk("one_done", o_done[0], 1);

        // Illegal configurations
        cfg(0, 4, 9); @(negedge clk); cfg_valid = 0;
        chk("ill_vill", o_vill[0], 1); chk("ill_vtype", o_vtype[0], 0);
        chk("ill_vl", o_vl[0], 0); chk("ill_ready", o_ready[0], 1); chk("ill_done", o_done[0], 1);
        @(negedge clk);
        chk("ill_done_end", o_done[0], 0);
        cfg(4, 0, 9); @(negedge clk); cfg_valid = 0;
        chk("ill_sew_vill", o_vill[0], 1);
        cfg(3, 0, 0); @(negedge clk); cfg_valid = 0;
        chk("e32_vill", o_vill[1], 1); chk("e64_vill", o_vill[0], 0);
        chk("e64_vtype", o_vtype[0], 7'b1011000); chk("e64_done", o_done[0], 1);

        // Abort wins over strip_next
        cfg(0, 3, 200); @(negedge clk); cfg_valid = 0;
        chk("ab_vl", o_vl[0], 128); chk("ab_rem", o_rem[0], 72);
        strip_next = 1; abort = 1; @(negedge clk); strip_next = 0; abort = 0;
        chk("ab_ready", o_ready[0], 1); chk("ab_vl0", o_vl[0], 0); chk("ab_rem0", o_rem[0], 0);
        chk("ab_done", o_done[0], 0); chk("ab_vtype", o_vtype[0], 7'b1000011);
        chk("ab_cnt", o_cnt[0], 1);
        @(negedge clk);
        chk("ab_done2", o_done[0], 0);

        // Request held during ACTIVE is taken on the first IDLE cycle
        cfg(2, 2, 10); @(negedge clk);
        cfg(0, 0, 5);
        chk("hold_ready", o_ready[0], 0); chk("hold_vtype", o_vtype[0], 7'b1010010);
        @(negedge clk);
        chk("hold_vtype2", o_vtype[0], 7'b1010010);
        strip_next = 1; @(negedge clk); strip_next = 0;
        chk("hold_idle", o_ready[0], 1); chk("hold_done", o_done[0], 1);
        chk("hold_vtype3", o_vtype[0], 7'b1010010);
        @(negedge clk); cfg_valid = 0;
        chk("hold_acc_vtype", o_vtype[0], 7'b1000000); chk("hold_acc_vl", o_vl[0], 5);
        strip_next = 1; @(negedge clk); strip_next = 0;
        @(negedge clk);

        // Asynchronous reset mid-sequence
        cfg(0, 0, 100); @(negedge clk); cfg_valid = 0;
        #1 rst = 1'b1;
        #1;
        chk("arst_vl", o_vl[0], 0); chk("arst_vtype", o_vtype[0], 0);
        chk("arst_rem", o_rem[0], 0); chk("arst_cnt", o_cnt[0], 0);
        chk("arst_ready", o_ready[0], 1); chk("arst_last", o_last[0], 0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("arst_nodone", o_done[0], 0);
        end

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            cfg_valid  = ($urandom_range(0, 3) == 0);
            cfg_sew    = ($urandom_range(0, 11) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            cfg_lmul   = ($urandom_range(0, 11) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            cfg_avl    = ($urandom_range(0, 7) == 0) ? '0 : AVL_W'($urandom_range(1, 255));
            strip_next = ($urandom_range(0, 1) == 0);
            abort      = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #1 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end
        @(negedge clk);
        cfg_valid = 0; strip_next = 0; abort = 0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vcfg_stripmine.md
VCFG_STRIPMINE -- requirements
Module: vcfg_stripmine

Interface
REQ-001 Parameter VLEN, default 128, vector register length in bits; SHALL be a power of 2 and at least 64.
REQ-002 Parameter ELEN, default 64, maximum element width in bits; SHALL be 32 or 64.
REQ-003 Parameter AVL_W, default 8, width of AVL/vl/count paths; SHALL be at least clog2(VLEN)+1.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 cfg_valid  in  1  configuration request valid.
REQ-007 cfg_ready  out  1  block can accept a configuration.
REQ-008 cfg_sew  in  3  encoded SEW: 000=8, 001=16, 010=32, 011=64.
REQ-009 cfg_lmul  in  3  encoded LMUL: 000=x1, 001=x2, 010=x4, 011=x8.
REQ-010 cfg_avl  in  AVL_W  application vector length.
REQ-011 strip_next  in  1  consumer finished the current strip; single-cycle pulse.
REQ-012 abort  in  1  cancel the active strip-mine sequence.
REQ-013 vl  out  AVL_W  current strip length.
REQ-014 vtype  out  7  [6]=valid, [5:3]=SEW, [2:0]=LMUL.
REQ-015 vill  out  1  last accepted configuration was illegal.
REQ-016 avl_rem  out  AVL_W  elements remaining after the current strip.
REQ-017 strip_cnt  out  AVL_W  number of strips issued in the current sequence.
REQ-018 strip_last  out  1  current strip is the final one.
REQ-019 done  out  1  one-cycle pulse marking sequence completion.

Function
REQ-020 The block SHALL implement two states, IDLE and ACTIVE; cfg_ready SHALL equal (state==IDLE).
REQ-021 Acceptance SHALL occur at the edge where cfg_valid&cfg_ready; vl, vtype, vill, avl_rem and strip_cnt SHALL update at that same edge (1-cycle latency).
REQ-022 The configuration is illegal when cfg_lmul[2]=1, cfg_sew[2]=1, or SEW bits > ELEN.
REQ-023 Illegal config on accept: vill=1, vtype=0, vl=0, avl_rem=0, strip_cnt=0; stay IDLE; done=1 the next cycle.
REQ-024 Legal config on accept: vill=0; vtype={1,sew,lmul}; vlmax=(VLEN>>(sew+3))<<lmul, registered internally.
REQ-025 Legal config, cfg_avl=0: vl=0, avl_rem=0, strip_cnt=0; stay IDLE; done=1 the next cycle.
REQ-026 Legal config, cfg_avl>0: vl=min(vlmax,cfg_avl), avl_rem=cfg_avl-vl, strip_cnt=1; go to ACTIVE.
REQ-027 strip_last SHALL equal (state==ACTIVE)&&(avl_rem==0), combinationally from registers.
REQ-028 strip_next in ACTIVE with avl_rem>0: vl<=min(vlmax,avl_rem), avl_rem<=avl_rem-min(vlmax,avl_rem), strip_cnt<=strip_cnt+1.
REQ-029 strip_next in ACTIVE with avl_rem==0: go to IDLE, done=1 the next cycle; vl, vtype, strip_cnt hold.
REQ-030 abort in ACTIVE: go to IDLE; vl<=0, avl_rem<=0; vtype and strip_cnt hold; no done pulse.
REQ-031 If abort and strip_next are both asserted in ACTIVE, abort SHALL take priority.
REQ-032 strip_next and abort in IDLE SHALL be ignored; cfg_valid in ACTIVE SHALL be ignored (not accepted).
REQ-033 done SHALL be registered and high for exactly one cycle per completion event.
REQ-034 vtype, vl and vill SHALL hold between sequences (CSR persistence) until the next accept or reset.

Reset
REQ-035 While rst=1, without waiting for a clock edge: state=IDLE; vl, vtype, avl_rem, strip_cnt=0; vill, done=0. Therefore strip_last=0 and cfg_ready=1.
REQ-036 Reset asserted mid-sequence SHALL discard the sequence with no done pulse.

Verification (VLEN=128, ELEN=64)
REQ-037 SEW=000, LMUL=000, AVL=40 -> vl=16/avl_rem=24; strip_next -> vl=16/avl_rem=8; strip_next -> vl=8/avl_rem=0, strip_last=1; strip_next -> IDLE, done pulse, strip_cnt=3.
REQ-038 SEW=010, LMUL=010, AVL=10 -> vlmax=16, vl=10, avl_rem=0, strip_last=1 on the first cycle; strip_next -> done.
REQ-039 LMUL=100 or SEW=100 -> vill=1, vtype=0, vl=0, cfg_ready stays 1, one done pulse; repeat with ELEN=32 and SEW=011 -> vill=1.
REQ-040 SEW=000, LMUL=011, AVL=200 -> vl=128/avl_rem=72; abort and strip_next together -> IDLE, vl=0, avl_rem=0, no done pulse.
REQ-041 cfg_valid held high during ACTIVE with a different SEW -> cfg_ready=0 and vtype unchanged; the request is accepted on the first IDLE cycle.
REQ-042 rst pulsed between clock edges in ACTIVE -> all outputs 0 immediately; no done pulse after release.
